nfc_sys_status_ctrl: RTL
========================

NFC_SYS_STATUS_CTRL -- requirements
Module: nfc_sys_status_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 3, meaning the number of LED/status channels (legal range 1..8).
REQ-002 The block SHALL have parameter LOCK_HOLD_CYC, default 1024, meaning the clocks for which lock must be stable before reset release (minimum 1).
REQ-003 The block SHALL have parameter STRETCH_CYC, default 8136000, meaning the pulse-stretch length in clocks (100 ms at 81.36 MHz; minimum 1).
REQ-004 The block SHALL have parameter BLINK_HALF_CYC, default 20340000, meaning the blink half-period in clocks (minimum 1).
REQ-005 The block SHALL have port clk, input, 1 bit: system clock (81.36 MHz nominal).
REQ-006 The block SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port pll_locked, input, 1 bit: PLL lock status, asynchronous to clk.
REQ-008 The block SHALL have port ch_event, input, N_CH bits: per-channel status/activity level, synchronous to clk.
REQ-009 The block SHALL have port ch_mode, input, 2*N_CH bits: per-channel mode, bits [2i+1:2i] for channel i; 00 OFF, 01 DIRECT, 10 STRETCH, 11 BLINK.
REQ-010 The block SHALL have port sys_rstn, output, 1 bit: registered active-low reset for the NFC subsystem.
REQ-011 The block SHALL have port sys_ready, output, 1 bit: high when the sequencer is in RUN.
REQ-012 The block SHALL have port led, output, N_CH bits: per-channel LED drive, active-high, registered.
REQ-013 The block SHALL have port lock_loss_cnt, output, 8 bits: count of lock losses seen while in RUN.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchroniser; lk_s denotes its output.
REQ-015 The sequencer SHALL have states WAIT_LOCK, HOLD and RUN, and SHALL reset to WAIT_LOCK.
REQ-016 In WAIT_LOCK with lk_s=1, the sequencer SHALL clear the hold counter and go to HOLD.
REQ-017 In HOLD with lk_s=0, the sequencer SHALL go to WAIT_LOCK and clear the hold counter.
REQ-018 In HOLD, the counter SHALL increment each clock, and the sequencer SHALL go to RUN when the counter reaches LOCK_HOLD_CYC-1.
REQ-019 In RUN with lk_s=0, the sequencer SHALL go to WAIT_LOCK and increment lock_loss_cnt, saturating at 255.
REQ-020 sys_rstn and sys_ready SHALL be registered copies of (state==RUN); they assert exactly LOCK_HOLD_CYC+3 clocks after the first edge sampling pll_locked=1 with lock stable, and deassert 3 clocks after the first edge sampling pll_locked=0.
REQ-021 A lock glitch shorter than one clock that is not captured SHALL have no effect; a captured glitch in HOLD SHALL restart the full hold count.
REQ-022 In OFF mode, led[i] SHALL be 0.
REQ-023 In DIRECT mode, led[i] SHALL equal ch_event[i] delayed one clock.
REQ-024 In STRETCH mode, each clock with ch_event[i]=1 SHALL load the channel counter with STRETCH_CYC; otherwise a nonzero counter SHALL decrement.
REQ-025 In STRETCH mode, led[i] SHALL be registered (counter!=0 after update); a re-trigger during stretch SHALL extend the stretch, not restart a gap.
REQ-026 In BLINK mode with ch_event[i]=1, led[i] SHALL go 1 on the next clock, then toggle every BLINK_HALF_CYC clocks.
REQ-027 In BLINK mode with ch_event[i]=0, led[i] SHALL go 0 next clock and the phase counter SHALL clear, so a new assertion restarts at phase 1.
REQ-028 Any change of ch_mode[i] SHALL clear the channel counters and drive led[i]=0 for one clock; the new mode SHALL take effect from the following clock.
REQ-029 Channels SHALL be fully independent; counter widths SHALL be $clog2(param+1) bits.
REQ-030 LED logic SHALL operate regardless of sequencer state.

Reset
REQ-031 While rstn=0, the block SHALL hold state=WAIT_LOCK, sys_rstn=0, sys_ready=0, led=0, lock_loss_cnt=0, all counters=0, and synchroniser flops=0.
REQ-032 Reset assertion SHALL take effect asynchronously; release SHALL be sampled on the next clk edge, and mid-HOLD or mid-stretch reset SHALL discard all progress.

Verification (N_CH=3, LOCK_HOLD_CYC=16, STRETCH_CYC=10, BLINK_HALF_CYC=4)
REQ-033 The bench SHALL apply pll_locked=1 from cycle 0 and check sys_rstn=1 at cycle 19, not at cycle 18.
REQ-034 The bench SHALL drop pll_locked for 2 clocks at HOLD count 10 and check that sys_rstn rises 16+3 clocks after lock returns, with lock_loss_cnt=0.
REQ-035 The bench SHALL drop lock 300 times in RUN and check lock_loss_cnt=255 and sys_rstn=0 three clocks after each drop.
REQ-036 The bench SHALL drive ch0 in STRETCH with a 1-clock event at t=0 and t=5, and check led[0]=1 for cycles 1..15 and 0 at cycle 16.
REQ-037 The bench SHALL drive ch1 in BLINK with event high for 20 clocks and check led[1] follows the pattern 1111 0000 1111 0000 1111 starting at cycle 1, then 0.
REQ-038 The bench SHALL switch ch2 from DIRECT to BLINK while the event is high and check led[2]=0 for one clock, then 1; it SHALL also assert rstn=0 mid-stretch and check all outputs are 0 immediately.

Source files
------------

// File: rtl/nfc_sys_status_ctrl.sv
// NFC subsystem status controller: PLL-lock reset sequencer plus per-channel LED
// drivers (off / direct / pulse-stretch / blink).
module nfc_sys_status_ctrl #(
  parameter int unsigned N_CH           = 3,
  parameter int unsigned LOCK_HOLD_CYC  = 1024,
  parameter int unsigned STRETCH_CYC    = 8136000,
  parameter int unsigned BLINK_HALF_CYC = 20340000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pll_locked,
  input  logic [N_CH-1:0]   ch_event,
  input  logic [2*N_CH-1:0] ch_mode,
  output logic              sys_rstn,
  output logic              sys_ready,
  output logic [N_CH-1:0]   led,
  output logic [7:0]        lock_loss_cnt
);

  localparam int unsigned HW = $clog2(LOCK_HOLD_CYC + 1);
  localparam int unsigned SW = $clog2(STRETCH_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF_CYC + 1);

  localparam logic [HW-1:0] HoldLast    = HW'(LOCK_HOLD_CYC - 1);
  localparam logic [SW-1:0] StretchLoad = SW'(STRETCH_CYC);
  localparam logic [BW-1:0] BlinkHalf   = BW'(BLINK_HALF_CYC);

  localparam logic [1:0] ModeOff     = 2'b00;
  localparam logic [1:0] ModeDirect  = 2'b01;
  localparam logic [1:0] ModeStretch = 2'b10;
  localparam logic [1:0] ModeBlink   = 2'b11;

  // Lock synchroniser
  logic sync1, lk_s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk_s  <= sync1;
    end
  end

  // Reset sequencer
  typedef enum logic [1:0] {StWaitLock, StHold, StRun} seq_e;

  seq_e            state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]      loss_q, loss_d;
  logic            run_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    loss_d     = loss_q;
    case (state_q)
      StWaitLock: begin
        if (lk_s) begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
      end
      StHold: begin
        if (!lk_s) begin
          state_d    = StWaitLock;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      StRun: begin
        if (!lk_s) begin
          state_d = StWaitLock;
          if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
        end
      end
      default: state_d = StWaitLock;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StWaitLock;
      hold_cnt_q <= '0;
      loss_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      loss_q     <= loss_d;
      run_q      <= (state_q == StRun);
    end
  end

  assign sys_rstn      = run_q;
  assign sys_ready     = run_q;
  assign lock_loss_cnt = loss_q;

  // Per-channel LED drivers, independent of the sequencer
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]    mode_q;
    logic [1:0]    mode_cur;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          led_q, led_d;

    assign mode_cur = ch_mode[2*i +: 2];

    always_comb begin
      scnt_d = scnt_q;
      bcnt_d = bcnt_q;
      led_d  = 1'b0;
      // A mode change blanks the LED for one clock and discards counter progress
      if (mode_cur != mode_q) begin
        scnt_d = '0;
        bcnt_d = '0;
      end else begin
        case (mode_cur)
          ModeOff:    led_d = 1'b0;
          ModeDirect: led_d = ch_event[i];
          ModeStretch: begin
            if (ch_event[i]) begin
              scnt_d = StretchLoad;
            end else if (scnt_q != '0) begin
              scnt_d = scnt_q - SW'(1);
            end
            led_d = (scnt_d != '0);
          end
          ModeBlink: begin
            // bcnt == 0 marks a fresh assertion; otherwise it counts 1..BLINK_HALF_CYC
            if (!ch_event[i]) begin
              bcnt_d = '0;
              led_d  = 1'b0;
            end else if (bcnt_q == '0) begin
              bcnt_d = BW'(1);
              led_d  = 1'b1;
            end else if (bcnt_q == BlinkHalf) begin
              bcnt_d = BW'(1);
              led_d  = ~led_q;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
              led_d  = led_q;
            end
          end
          default: led_d = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        mode_q <= ModeOff;
        scnt_q <= '0;
        bcnt_q <= '0;
        led_q  <= 1'b0;
      end else begin
        mode_q <= mode_cur;
        scnt_q <= scnt_d;
        bcnt_q <= bcnt_d;
        led_q  <= led_d;
      end
    end

    assign led[i] = led_q;
  end

endmodule
